// File: rtl/wallace_pkg.sv
// Shared widths, types and tree-sizing helper for the 16x16 Wallace multiplier.
//   OP_W        : operand width
//   PROD_W      : product width
//   prod_t      : one weight-aligned row / the product
//   TREE_LEVELS : number of 3:2 reduction levels (16->11->8->6->4->3->2)
//   rows_at()   : row count present at the input of a given level
package wallace_pkg;

  localparam int OP_W        = 16;
  localparam int PROD_W      = 32;
  localparam int TREE_LEVELS = 6;

  typedef logic [PROD_W-1:0] prod_t;

  // Each level turns every full group of three rows into two (sum, carry)
  // and passes the leftover rows through untouched.
  function automatic int rows_at(int unsigned lvl);
    int n;
    n = OP_W;
    for (int unsigned k = 0; k < lvl; k++) begin
      n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

endpackage

// File: rtl/wallace_fa.sv
// 1-bit full adder used as the 3:2 compressor in the Wallace tree and as the
// ripple cell of the final carry-propagate adder.
//   a, b, cin : addend bits of equal weight
//   s         : sum bit (same weight)
//   cout      : carry bit (next weight up)
module wallace_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/wallace_16bit.sv
// Two-stage pipelined unsigned 16x16 -> 32 multiplier.
// Operands are registered, reduced by a Wallace tree of 3:2 full adders down to
// two rows, summed by a ripple adder and registered into Z.
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : A/B carry a valid operand pair
//   A, B      : unsigned operands
//   out_valid : Z carries a valid product (in_valid delayed two edges)
//   Z         : product A*B, updated every cycle
module wallace_16bit
  import wallace_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  output logic            out_valid,
  output logic [PROD_W-1:0] Z
);

  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic            vin_q, vin_d;
  prod_t           z_q, z_d;
  logic            vout_q, vout_d;

  // Partial-product rows, already shifted to their weight.
  prod_t pp [OP_W];
  for (genvar i = 0; i < OP_W; i++) begin : pp_g
    assign pp[i] = prod_t'(a_q & {OP_W{b_q[i]}}) << i;
  end

  // Row-level Wallace reduction. Every row is kept at full product width;
  // constant-zero bit positions fold away. The carry out of column 31 is
  // dropped since the exact product never exceeds 32 bits.
  for (genvar k = 0; k < TREE_LEVELS; k++) begin : lvl_g
    localparam int N_IN  = rows_at(k);
    localparam int N_GRP = N_IN / 3;
    localparam int N_OUT = rows_at(k + 1);

    prod_t r_in  [N_IN];
    prod_t r_out [N_OUT];

    if (k == 0) begin : src_g
      for (genvar r = 0; r < N_IN; r++) begin : cp_g
        assign r_in[r] = pp[r];
      end
    end else begin : src_g
      for (genvar r = 0; r < N_IN; r++) begin : cp_g
        assign r_in[r] = lvl_g[k-1].r_out[r];
      end
    end

    for (genvar g = 0; g < N_GRP; g++) begin : grp_g
      prod_t s_row, c_row;
      assign c_row[0] = 1'b0;
      for (genvar col = 0; col < PROD_W - 1; col++) begin : col_g
        wallace_fa u_fa (
          .a    (r_in[3*g][col]),
          .b    (r_in[3*g+1][col]),
          .cin  (r_in[3*g+2][col]),
          .s    (s_row[col]),
          .cout (c_row[col+1])
        );
      end
      assign s_row[PROD_W-1] = r_in[3*g][PROD_W-1] ^ r_in[3*g+1][PROD_W-1]
                             ^ r_in[3*g+2][PROD_W-1];
      assign r_out[2*g]   = s_row;
      assign r_out[2*g+1] = c_row;
    end

    for (genvar r = 0; r < N_IN - 3 * N_GRP; r++) begin : pass_g
      assign r_out[2*N_GRP+r] = r_in[3*N_GRP+r];
    end
  end

  // Final ripple carry-propagate adder; bit 0 is a half adder.
  prod_t                 row_x, row_y, sum;
  logic [PROD_W-1:1]     cpa_c;

  assign row_x    = lvl_g[TREE_LEVELS-1].r_out[0];
  assign row_y    = lvl_g[TREE_LEVELS-1].r_out[1];
  assign sum[0]   = row_x[0] ^ row_y[0];
  assign cpa_c[1] = row_x[0] & row_y[0];

  for (genvar col = 1; col < PROD_W - 1; col++) begin : cpa_g
    wallace_fa u_fa (
      .a    (row_x[col]),
      .b    (row_y[col]),
      .cin  (cpa_c[col]),
      .s    (sum[col]),
      .cout (cpa_c[col+1])
    );
  end
  assign sum[PROD_W-1] = row_x[PROD_W-1] ^ row_y[PROD_W-1] ^ cpa_c[PROD_W-1];

  always_comb begin
    a_d    = A;
    b_d    = B;
    vin_d  = in_valid;
    z_d    = sum;
    vout_d = vin_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      vin_q  <= 1'b0;
      z_q    <= '0;
      vout_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      vin_q  <= vin_d;
      z_q    <= z_d;
      vout_q <= vout_d;
    end
  end

  assign Z         = z_q;
  assign out_valid = vout_q;

endmodule

// File: tb/tb_wallace_16bit.sv
// Scoreboard bench for wallace_16bit: the driver pushes {due cycle, product}
// for every valid pair; the monitor checks out_valid/Z every cycle.
module tb_wallace_16bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] A, B;
  logic        out_valid;
  logic [31:0] Z;

  wallace_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .Z         (Z)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] z;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; they are sampled by the next
  // edge, so the product is due two edges later.
  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic v);
    @(posedge clk);
    #1;
    A        = a;
    B        = b;
    in_valid = v;
    if (v) q.push_back('{due: cyc + 2, z: 32'(a) * 32'(b)});
  endtask

  // Mid-cycle asynchronous reset pulse; everything in flight is dropped.
  task automatic pulse_rst();
    @(posedge clk);
    #1;
    A        = '0;
    B        = '0;
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_z", Z, 32'h0);
    check("async_rst_valid", {31'b0, out_valid}, 32'h0);
    q.delete();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rst_valid", {31'b0, out_valid}, 32'h0);
      check("rst_z", Z, 32'h0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      check("out_valid", {31'b0, out_valid}, 32'h1);
      check("z", Z, e.z);
    end else begin
      check("idle_valid", {31'b0, out_valid}, 32'h0);
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    A        = '0;
    B        = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // basic and corner products
    drive(16'hFFFF, 16'h0002, 1'b1);
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    drive(16'h8000, 16'h8000, 1'b1);
    drive(16'h0001, 16'hABCD, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);
    // back-to-back pipelining
    drive(16'h0003, 16'h0005, 1'b1);
    drive(16'h1234, 16'h0010, 1'b1);
    drive(16'hFFFF, 16'h0001, 1'b1);
    drive(16'h00FF, 16'h0101, 1'b1);

    // async reset while Z is nonzero, then zero operands after release
    pulse_rst();
    drive(16'h0000, 16'h0000, 1'b1);
    drive(16'h0000, 16'h0000, 1'b0);
    repeat (3) drive(16'h0000, 16'h0000, 1'b0);

    // reset with a max product in flight: it must never emerge
    drive(16'hFFFF, 16'hFFFF, 1'b1);
    pulse_rst();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("flushed_z", {31'b0, (Z == 32'hFFFE0001)}, 32'h0);
    end

    // random traffic
    for (int i = 0; i < 10000; i++) begin
      drive(16'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (4) drive(16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
